// File: rtl/mole_pkg.sv
// mole_pkg: shared types and constants for the mole responder.
// Holds the round state enum, LFSR constants, score limits and the
// saturating score / LFSR step helpers used by mole_controller and lfsr16.
package mole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DONE = 2'd2
  } mole_state_e;

  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_SEED      = 16'hACE1;
  localparam logic [11:0] PENALTY_POINTS = 12'd50;
  localparam logic [11:0] SCORE_MAX      = 12'd4095;
  localparam int          REACTION_W     = 13;

  // One right-shift step of the Galois LFSR; taps fold in when bit 0 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] nxt;
    nxt = {1'b0, v[15:1]};
    if (v[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // Score plus points, clamped at SCORE_MAX.
  function automatic logic [11:0] score_add(input logic [11:0] s, input logic [11:0] pts);
    logic [12:0] sum;
    sum = {1'b0, s} + {1'b0, pts};
    if (sum > {1'b0, SCORE_MAX}) begin
      return SCORE_MAX;
    end else begin
      return sum[11:0];
    end
  endfunction

  // Score minus points, clamped at zero.
  function automatic logic [11:0] score_sub(input logic [11:0] s, input logic [11:0] pts);
    if (s < pts) begin
      return 12'd0;
    end else begin
      return s - pts;
    end
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR used to pick the mole position.
// Reloads its seed on reset and steps every clock otherwise.
module lfsr16
  import mole_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] lfsr_r;

  // Seed on reset, otherwise advance one step per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  assign value = lfsr_r;

endmodule

// File: rtl/mole_controller.sv
// mole_controller: raises one pseudo-random mole per FSM request, times the
// player's reaction in milliseconds, pulses mole_complete at round end and
// keeps a saturating 12-bit score.
// Optional feature: define MOLE_PENALTY_EN to make a wrong button press end
// the round as a miss and deduct PENALTY_POINTS; undefined, wrong presses are
// ignored.
module mole_controller
  import mole_pkg::*;
#(
  parameter int CLKS_PER_MS = 50000,
  parameter int MAX_MS      = 5000,
  parameter int NUM_MOLES   = 8,
  parameter int POINTS_HIT  = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_flag,
  input  logic                  new_mole,
  input  logic [NUM_MOLES-1:0]  hit,
  output logic [NUM_MOLES-1:0]  mole_leds,
  output logic                  mole_complete,
  output logic                  hit_valid,
  output logic [REACTION_W-1:0] reaction_ms,
  output logic [11:0]           score
);

  localparam int POS_W = $clog2(NUM_MOLES);
  localparam int CYC_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CYC_W-1:0]      CYC_LAST    = CYC_W'(CLKS_PER_MS - 1);
  localparam logic [REACTION_W-1:0] MS_LIMIT    = REACTION_W'(MAX_MS);
  localparam logic [11:0]           HIT_PTS     = 12'(POINTS_HIT);
  localparam logic [NUM_MOLES-1:0]  ONE_HOT_LSB = {{(NUM_MOLES-1){1'b0}}, 1'b1};

`ifdef MOLE_PENALTY_EN
  localparam logic PENALTY_EN = 1'b1;
`else
  localparam logic PENALTY_EN = 1'b0;
`endif

  mole_state_e state_r, state_next_s;

  logic [15:0]           lfsr_value_s;
  logic                  lfsr_unused_s;
  logic [POS_W-1:0]      pos_raw_s, pos_s, prev_pos_r;
  logic [NUM_MOLES-1:0]  hit_q_r, rise_s;
  logic                  good_edge_s, bad_edge_s;
  logic                  start_s, hit_evt_s, pen_evt_s, miss_evt_s;
  logic [CYC_W-1:0]      cyc_cnt_r;
  logic [REACTION_W-1:0] ms_cnt_r;

  logic [NUM_MOLES-1:0]  mole_leds_r;
  logic                  mole_complete_r, hit_valid_r;
  logic [REACTION_W-1:0] reaction_ms_r;
  logic [11:0]           score_r;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value_s)
  );

  // Only the low bits choose the position; the upper bits just keep mixing.
  assign lfsr_unused_s = ^lfsr_value_s[15:POS_W];
  assign pos_raw_s     = lfsr_value_s[POS_W-1:0];
  // Avoid repeating the previous mole; NUM_MOLES is a power of two so the
  // increment wraps naturally.
  assign pos_s = (pos_raw_s == prev_pos_r) ? (pos_raw_s + POS_W'(1'b1)) : pos_raw_s;

  assign rise_s      = hit & ~hit_q_r;
  assign good_edge_s = |(rise_s & mole_leds_r);
  assign bad_edge_s  = |(rise_s & ~mole_leds_r);

  // Round state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and round-outcome decode; a correct press beats penalty and timeout.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    hit_evt_s    = 1'b0;
    pen_evt_s    = 1'b0;
    miss_evt_s   = 1'b0;
    if (!play_flag) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (new_mole) begin
            state_next_s = ST_UP;
            start_s      = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_UP: begin
          if (good_edge_s) begin
            hit_evt_s    = 1'b1;
            state_next_s = ST_DONE;
          end else if (PENALTY_EN && bad_edge_s) begin
            pen_evt_s    = 1'b1;
            state_next_s = ST_DONE;
          end else if (ms_cnt_r >= MS_LIMIT) begin
            miss_evt_s   = 1'b1;
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_UP;
          end
        end
        ST_DONE: begin
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Button history, LEDs, timers and round results.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q_r         <= {NUM_MOLES{1'b0}};
      prev_pos_r      <= {POS_W{1'b0}};
      mole_leds_r     <= {NUM_MOLES{1'b0}};
      cyc_cnt_r       <= {CYC_W{1'b0}};
      ms_cnt_r        <= {REACTION_W{1'b0}};
      mole_complete_r <= 1'b0;
      hit_valid_r     <= 1'b0;
      reaction_ms_r   <= {REACTION_W{1'b0}};
      score_r         <= 12'd0;
    end else begin
      hit_q_r         <= hit;
      mole_complete_r <= hit_evt_s | pen_evt_s | miss_evt_s;

      if (start_s) begin
        mole_leds_r <= ONE_HOT_LSB << pos_s;
        prev_pos_r  <= pos_s;
        cyc_cnt_r   <= {CYC_W{1'b0}};
        ms_cnt_r    <= {REACTION_W{1'b0}};
      end else if (state_r == ST_UP && state_next_s == ST_UP) begin
        if (cyc_cnt_r == CYC_LAST) begin
          cyc_cnt_r <= {CYC_W{1'b0}};
          ms_cnt_r  <= ms_cnt_r + {{(REACTION_W-1){1'b0}}, 1'b1};
        end else begin
          cyc_cnt_r <= cyc_cnt_r + {{(CYC_W-1){1'b0}}, 1'b1};
        end
      end else begin
        mole_leds_r <= {NUM_MOLES{1'b0}};
        cyc_cnt_r   <= {CYC_W{1'b0}};
        ms_cnt_r    <= {REACTION_W{1'b0}};
      end

      if (hit_evt_s) begin
        hit_valid_r   <= 1'b1;
        reaction_ms_r <= ms_cnt_r;
        score_r       <= score_add(score_r, HIT_PTS);
      end else if (pen_evt_s) begin
        hit_valid_r   <= 1'b0;
        reaction_ms_r <= ms_cnt_r;
        score_r       <= score_sub(score_r, PENALTY_POINTS);
      end else if (miss_evt_s) begin
        hit_valid_r   <= 1'b0;
        reaction_ms_r <= MS_LIMIT;
      end else begin
        hit_valid_r   <= hit_valid_r;
      end
    end
  end

  assign mole_leds     = mole_leds_r;
  assign mole_complete = mole_complete_r;
  assign hit_valid     = hit_valid_r;
  assign reaction_ms   = reaction_ms_r;
  assign score         = score_r;

endmodule

// File: tb/tb_mole_controller.sv
// tb_mole_controller: randomized rounds against a round-level reference model.
// The driver pushes each round's expected outcome into a queue; a negedge
// monitor pops and compares whenever mole_complete is seen.
module tb_mole_controller;

  localparam int CLKS = 2;
  localparam int MAXMS = 10;
  localparam int N = 8;
  localparam int PTS = 100;
  localparam int TOUT = MAXMS * CLKS + 1;
`ifdef MOLE_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, play_flag, new_mole;
  logic [N-1:0]  hit;
  logic [N-1:0]  mole_leds;
  logic          mole_complete, hit_valid;
  logic [12:0]   reaction_ms;
  logic [11:0]   score;

  mole_controller #(
    .CLKS_PER_MS (CLKS),
    .MAX_MS      (MAXMS),
    .NUM_MOLES   (N),
    .POINTS_HIT  (PTS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .play_flag     (play_flag),
    .new_mole      (new_mole),
    .hit           (hit),
    .mole_leds     (mole_leds),
    .mole_complete (mole_complete),
    .hit_valid     (hit_valid),
    .reaction_ms   (reaction_ms),
    .score         (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hv;
    int rms;
    int score;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  int m_prev, m_score, m_hv, m_rms;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: compare each round-end pulse with the oldest expected outcome.
  exp_t e;
  int prev_cmp = 0;
  always @(negedge clk) begin
    if (mole_complete === 1'b1) begin
      chk("complete_one_cycle", prev_cmp, 0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_complete: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("complete_cycle", cyc, e.cyc);
        chk("hit_valid", int'(hit_valid), e.hv);
        chk("reaction_ms", int'(reaction_ms), e.rms);
        chk("score", int'(score), e.score);
        chk("leds_off_in_done", int'(mole_leds), 0);
      end
    end
    prev_cmp <= (mole_complete === 1'b1) ? 1 : 0;
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] t;
    t = v >> 1;
    if (v[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  // One clock; the model LFSR follows the spec rule for that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) m_lfsr = 16'hACE1;
    else m_lfsr = lfsr_next(m_lfsr);
    #1;
  endtask

  function automatic int pick_pos();
    int raw;
    raw = int'(m_lfsr & 16'h0007);
    if (raw == m_prev) raw = (raw + 1) % N;
    m_prev = raw;
    return raw;
  endfunction

  // kind: 0 correct press, 1 no press, 2 wrong press, 3 held before, 4 correct+wrong
  task automatic run_round(input int kind, input int press_k, input int wrong_off);
    int pos, wrong, end_k, t0;
    exp_t x;
    pos = pick_pos();
    wrong = (pos + wrong_off) % N;
    end_k = TOUT;
    m_hv = 0;
    m_rms = MAXMS;
    if ((kind == 0 || kind == 4) && press_k <= TOUT) begin
      end_k = press_k;
      m_hv = 1;
      m_rms = (press_k - 1) / CLKS;
      m_score = (m_score + PTS > 4095) ? 4095 : m_score + PTS;
    end else if (kind == 2 && PEN && press_k <= TOUT) begin
      end_k = press_k;
      m_rms = (press_k - 1) / CLKS;
      m_score = (m_score < 50) ? 0 : m_score - 50;
    end
    if (kind == 3) hit[pos] = 1'b1;
    new_mole = 1'b1;
    tick();
    new_mole = 1'b0;
    t0 = cyc;
    x.hv = m_hv; x.rms = m_rms; x.score = m_score; x.cyc = t0 + end_k;
    sb_q.push_back(x);
    chk("leds_onehot", int'(mole_leds), 1 << pos);
    chk("complete_low_at_rise", int'(mole_complete), 0);
    for (int k = 1; k <= end_k; k++) begin
      if (k == press_k && (kind == 0 || kind == 4)) hit[pos] = 1'b1;
      if (k == press_k && (kind == 2 || kind == 4)) hit[wrong] = 1'b1;
      if (kind == 1 && k == 2) new_mole = 1'b1;
      tick();
      new_mole = 1'b0;
    end
    hit = '0;
    if (kind == 1) new_mole = 1'b1;
    tick();
    new_mole = 1'b0;
    chk("leds_idle_after_round", int'(mole_leds), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, pk, wo;
    reset = 1'b1; play_flag = 1'b1; new_mole = 1'b0; hit = '0;
    m_prev = 0; m_score = 0; m_hv = 0; m_rms = 0; m_lfsr = 16'hACE1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_leds", int'(mole_leds), 0);
    chk("rst_complete", int'(mole_complete), 0);
    chk("rst_hit_valid", int'(hit_valid), 0);
    chk("rst_reaction", int'(reaction_ms), 0);
    chk("rst_score", int'(score), 0);

    // Directed rounds from the plan
    run_round(0, 7, 1);
    run_round(2, 4, 2);
    run_round(2, 6, 5);
    run_round(2, 3, 7);
    run_round(1, 0, 1);
    run_round(3, 0, 1);
    run_round(0, TOUT, 1);
    run_round(0, TOUT + 1, 1);
    run_round(4, 5, 3);

    // play_flag dropped mid-round: no pulse, results held
    begin
      int pos;
      pos = pick_pos();
      new_mole = 1'b1; tick(); new_mole = 1'b0;
      chk("pf_leds_on", int'(mole_leds), 1 << pos);
      repeat (4) tick();
      play_flag = 1'b0;
      tick();
      chk("pf_leds_off", int'(mole_leds), 0);
      chk("pf_score_held", int'(score), m_score);
      chk("pf_hv_held", int'(hit_valid), m_hv);
      chk("pf_rms_held", int'(reaction_ms), m_rms);
      new_mole = 1'b1; tick(); new_mole = 1'b0;
      chk("pf_new_mole_ignored", int'(mole_leds), 0);
      play_flag = 1'b1;
      repeat (2) tick();
      chk("pf_still_idle", int'(mole_leds), 0);
    end

    // Reset mid-round clears everything
    begin
      int pos;
      pos = pick_pos();
      new_mole = 1'b1; tick(); new_mole = 1'b0;
      repeat (3) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      m_prev = 0; m_score = 0; m_hv = 0; m_rms = 0;
      chk("mr_leds", int'(mole_leds), 0);
      chk("mr_score", int'(score), 0);
      chk("mr_hit_valid", int'(hit_valid), 0);
      chk("mr_reaction", int'(reaction_ms), 0);
      chk("mr_complete", int'(mole_complete), 0);
    end

    // Randomized rounds
    for (int r = 0; r < 50; r++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) kind = 0;
      else if (kind == 6) kind = 1;
      else if (kind == 7) kind = 2;
      else if (kind == 8) kind = 3;
      else kind = 4;
      pk = $urandom_range(1, TOUT + 3);
      wo = $urandom_range(1, N - 1);
      run_round(kind, pk, wo);
    end

    // Drive the score into saturation
    for (int r = 0; r < 45; r++) begin
      run_round(0, $urandom_range(1, 4), 1);
    end
    chk("score_saturated", int'(score), 4095);

    tick();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mole_controller.md
# mole_controller

Game-side responder for the reaction-time FSM. It consumes the FSM's `new_mole` request and `play_flag`, lights one pseudo-randomly chosen mole LED, and times the player's button reaction in milliseconds. It closes each round by pulsing `mole_complete` back to the FSM and maintains the 12-bit running `score` that the FSM compares against its game-over threshold.

## Interface
Parameters:
- `CLKS_PER_MS`, 50000: clock cycles per millisecond (50 MHz).
- `MAX_MS`, 5000: mole lifetime in ms, range 1..8191.
- `NUM_MOLES`, 8: number of mole LEDs/buttons; power of two, 2..16.
- `POINTS_HIT`, 100: score added per valid hit.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; clears all state including `score`.
- `play_flag`  in  1  FSM is in PLAY; low forces IDLE.
- `new_mole`  in  1  one-cycle request from FSM to raise a mole.
- `hit`  in  NUM_MOLES  debounced, synchronised button levels, 1 = pressed.
- `mole_leds`  out  NUM_MOLES  one-hot active mole, 0 when none.
- `mole_complete`  out  1  one-cycle pulse when the round ends.
- `hit_valid`  out  1  last round ended in a hit; held until next round ends.
- `reaction_ms`  out  13  last round's reaction time; MAX_MS on miss.
- `score`  out  12  running score, saturating at 0 and 4095.

## Operation
- States: IDLE, UP, DONE.
- IDLE: `mole_leds`=0. `new_mole`=1 with `play_flag`=1 -> UP next cycle. Position and timers are loaded on that edge.
- UP: one LED lit. Cycle counter runs 0..CLKS_PER_MS-1; `ms_count` increments on wrap.
  - Rising edge on the correct `hit` bit -> DONE as a hit: `hit_valid`=1, `reaction_ms`=`ms_count`, `score` += POINTS_HIT (saturating).
  - `ms_count`==MAX_MS -> DONE as a miss: `hit_valid`=0, `reaction_ms`=MAX_MS, score unchanged.
- DONE: `mole_leds`=0, `mole_complete`=1 for exactly one cycle, then IDLE.
- Rising edge detect: `hit & ~hit_q`, where `hit_q` is registered every cycle in all states. A button already held when the mole rises does not count.
- Position: a 16-bit Galois LFSR (taps 0xB400, seed 0xACE1) free-runs every cycle from reset. Position = `lfsr[log2(NUM_MOLES)-1:0]`. If equal to the previous position, use position+1 mod NUM_MOLES. The previous position resets to 0.
- Simultaneous events:
  - Correct-hit rising edge in the same cycle as timeout -> hit wins.
  - Several rising edges including the correct one -> hit.
- `new_mole` in UP or DONE is ignored; requests are not queued.
- `play_flag` low in any state -> IDLE next cycle. LEDs clear and timers zero. No `mole_complete` pulse. `score`, `reaction_ms` and `hit_valid` are held.
- `reset` mid-round -> IDLE next cycle, all outputs at reset values. The LFSR reloads its seed.

## Timing
- Reset values: `mole_leds`=0, `mole_complete`=0, `hit_valid`=0, `reaction_ms`=0, `score`=0, state IDLE.
- All outputs are registered.
- `new_mole` sampled at edge T -> `mole_leds` valid from T+1.
- Correct rising edge on `hit` at edge H -> DONE at H+1: `mole_complete`=1 and `reaction_ms`/`score`/`hit_valid` updated. IDLE at H+2.
- Earliest next mole: `new_mole` at H+2 -> LEDs at H+3.
- Timeout: DONE entered on the edge after `ms_count` reaches MAX_MS, i.e. MAX_MS*CLKS_PER_MS+1 cycles after LED-on.

## Configuration
- `MOLE_PENALTY_EN` defined: in UP, a rising edge on any wrong `hit` bit with no correct edge in the same cycle ends the round as a miss. That round gives `reaction_ms`=`ms_count`, `hit_valid`=0 and `score` -= 50 saturating at 0, then DONE as normal.
- Undefined: wrong presses are ignored.

## Structure
- `mole_pkg` holds:
  - the state enum;
  - LFSR_TAPS and LFSR_SEED;
  - PENALTY_POINTS=50;
  - SCORE_MAX=4095;
  - the `reaction_ms` width constant (13).
- Sub-module `lfsr16` has ports `clk`, `reset` and `value[15:0]`, and free-runs.
- Top file contains the FSM, timers, edge detect and score.

## Test plan
Use CLKS_PER_MS=2, MAX_MS=10, NUM_MOLES=8.
- Reset, then `new_mole` pulse with `play_flag`=1 -> `mole_leds` one-hot next cycle; `mole_complete`=0.
- Press the correct button 7 cycles after LED-on -> one-cycle `mole_complete`, `hit_valid`=1, `reaction_ms`=3, `score`=100.
- No press -> `mole_complete` 21 cycles after LED-on, `hit_valid`=0, `reaction_ms`=10, `score` unchanged.
- Hold the correct button before LED-on -> no hit; round times out as a miss.
- Drop `play_flag` mid-round -> `mole_leds`=0 next cycle, no `mole_complete`, `score` held. Then `reset` -> `score`=0.
- With `MOLE_PENALTY_EN` and `score`=100, a wrong press -> miss, `score`=50. A second wrong press in the next round -> 0, and a third -> still 0.
